// File: rtl/ie_defs.sv
// Shared execute-unit definitions: stack operation kind, default stack page/pointer
// and the stack sequencer state encoding.
package ie_defs;

  typedef enum logic {
    STK_PUSH,
    STK_PULL
  } stack_op;

  localparam logic [7:0] STACK_PAGE_DEFAULT = 8'h01;
  localparam logic [7:0] SP_RESET_DEFAULT   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_PULL,
    S_DRAIN,
    S_FINISH
  } seq_state_e;

endpackage

// File: rtl/ie_rd_tag_pipe.sv
// Read-request tag pipeline: carries a valid bit and a lane index for each
// outstanding read, RD_LAT stages deep, frozen while halt_i is high.
module ie_rd_tag_pipe #(
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned IDX_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_i,
  input  logic             issue_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             ret_vld_o,
  output logic [IDX_W-1:0] ret_idx_o,
  output logic             front_idle_o
);

  logic [RD_LAT-1:0]            vld_q, vld_d;
  logic [RD_LAT-1:0][IDX_W-1:0] idx_q, idx_d;
  logic                         front_idle_q, front_idle_d;

  // front_idle: nothing in flight except possibly the stage that retires next
  always_comb begin
    vld_d        = vld_q;
    idx_d        = idx_q;
    front_idle_d = 1'b1;
    vld_d[0]     = issue_i;
    idx_d[0]     = idx_i;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      vld_d[i] = vld_q[i-1];
      idx_d[i] = idx_q[i-1];
    end
    for (int i = 0; i < int'(RD_LAT) - 2; i++) begin
      if (vld_d[i]) front_idle_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q        <= '0;
      idx_q        <= '0;
      front_idle_q <= 1'b1;
    end else if (!halt_i) begin
      vld_q        <= vld_d;
      idx_q        <= idx_d;
      front_idle_q <= front_idle_d;
    end
  end

  assign ret_vld_o    = vld_q[RD_LAT-1];
  assign ret_idx_o    = idx_q[RD_LAT-1];
  assign front_idle_o = front_idle_q;

endmodule

// File: rtl/ie_stack_seq.sv
// Stack-transfer sequencer: owns the stack pointer and runs multi-byte push or
// pipelined pull bursts on the page-relative hardware stack.
module ie_stack_seq
  import ie_defs::*;
#(
  parameter int unsigned             DATA_W     = 8,
  parameter int unsigned             ADDR_W     = 16,
  parameter int unsigned             SP_W       = 8,
  parameter logic [ADDR_W-SP_W-1:0]  STACK_PAGE = STACK_PAGE_DEFAULT,
  parameter int unsigned             MAX_BYTES  = 4,
  parameter int unsigned             RD_LAT     = 2,
  parameter logic [SP_W-1:0]         SP_RESET   = SP_RESET_DEFAULT
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                halt,
  input  logic                                start,
  input  logic                                op_pull,
  input  logic [$clog2(MAX_BYTES+1)-1:0]      nbytes,
  input  logic [MAX_BYTES*DATA_W-1:0]         push_data,
  input  logic                                sp_load,
  input  logic [SP_W-1:0]                     sp_load_val,
  input  logic [DATA_W-1:0]                   mem_data_in,
  output logic [ADDR_W-1:0]                   mem_addr,
  output logic [DATA_W-1:0]                   mem_data_out,
  output logic                                mem_write_en,
  output logic                                mem_read_en,
  output logic [SP_W-1:0]                     sp,
  output logic [MAX_BYTES*DATA_W-1:0]         pull_data,
  output logic                                busy,
  output logic                                done,
  output logic                                wrap
);

  localparam int unsigned NB_W  = $clog2(MAX_BYTES + 1);
  localparam int unsigned IDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;

  seq_state_e                       state_q, state_d;
  logic [NB_W-1:0]                  n_q, n_d, k_q, k_d, k_inc, n_clamp;
  logic [MAX_BYTES-1:0][DATA_W-1:0] data_q, data_d, pull_q, pull_d;
  logic [SP_W-1:0]                  sp_q, sp_d, sp_inc, sp_dec;
  logic [ADDR_W-1:0]                addr_q, addr_d;
  logic [DATA_W-1:0]                wdata_q, wdata_d;
  logic                             we_q, we_d, re_q, re_d;
  logic                             busy_q, busy_d, done_q, done_d, wrap_q, wrap_d;
  logic                             issue;
  logic [IDX_W-1:0]                 k_idx;
  logic                             ret_vld, front_idle;
  logic [IDX_W-1:0]                 ret_idx;
  stack_op                          op;

  assign k_inc  = k_q + NB_W'(1);
  assign k_idx  = k_q[IDX_W-1:0];
  assign sp_inc = sp_q + SP_W'(1);
  assign sp_dec = sp_q - SP_W'(1);

  ie_rd_tag_pipe #(
    .RD_LAT (RD_LAT),
    .IDX_W  (IDX_W)
  ) u_tag_pipe (
    .clk          (clk),
    .rst          (rst),
    .halt_i       (halt),
    .issue_i      (issue),
    .idx_i        (k_idx),
    .ret_vld_o    (ret_vld),
    .ret_idx_o    (ret_idx),
    .front_idle_o (front_idle)
  );

  // Next-state and datapath; read returns land independently of the FSM state
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    k_d     = k_q;
    data_d  = data_q;
    pull_d  = pull_q;
    sp_d    = sp_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    re_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    wrap_d  = wrap_q;
    issue   = 1'b0;
    op      = op_pull ? STK_PULL : STK_PUSH;
    n_clamp = (nbytes > NB_W'(MAX_BYTES)) ? NB_W'(MAX_BYTES) : nbytes;

    if (ret_vld) pull_d[ret_idx] = mem_data_in;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          n_d    = n_clamp;
          k_d    = '0;
          data_d = push_data;
          wrap_d = 1'b0;
          busy_d = 1'b1;
          if (n_clamp == '0)      state_d = S_FINISH;
          else if (op == STK_PULL) state_d = S_PULL;
          else                     state_d = S_PUSH;
        end else if (sp_load) begin
          sp_d = sp_load_val;
        end
      end
      S_PUSH: begin
        addr_d  = {STACK_PAGE, sp_q};
        wdata_d = data_q[k_idx];
        we_d    = 1'b1;
        sp_d    = sp_dec;
        k_d     = k_inc;
        if (sp_q == '0)    wrap_d  = 1'b1;
        if (k_inc == n_q)  state_d = S_FINISH;
      end
      S_PULL: begin
        addr_d = {STACK_PAGE, sp_inc};
        re_d   = 1'b1;
        issue  = 1'b1;
        sp_d   = sp_inc;
        k_d    = k_inc;
        if (sp_q == '1)   wrap_d  = 1'b1;
        if (k_inc == n_q) state_d = (RD_LAT == 1) ? S_FINISH : S_DRAIN;
      end
      S_DRAIN: begin
        if (front_idle) state_d = S_FINISH;
      end
      S_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      n_q     <= '0;
      k_q     <= '0;
      data_q  <= '0;
      pull_q  <= '0;
      sp_q    <= SP_RESET;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (!halt) begin
      state_q <= state_d;
      n_q     <= n_d;
      k_q     <= k_d;
      data_q  <= data_d;
      pull_q  <= pull_d;
      sp_q    <= sp_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      re_q    <= re_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
    end
  end

  assign mem_addr     = addr_q;
  assign mem_data_out = wdata_q;
  assign mem_write_en = we_q;
  assign mem_read_en  = re_q;
  assign sp           = sp_q;
  assign pull_data    = pull_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign wrap         = wrap_q;

endmodule

// File: tb/tb_ie_stack_seq.sv
// Directed bench for ie_stack_seq: push, pull, wrap, clamp/ignore, halt and
// mid-burst reset scenarios against a 2-cycle-latency stack-page memory model.
module tb_ie_stack_seq;

  logic        clk, rst, halt, start, op_pull, sp_load;
  logic [2:0]  nbytes;
  logic [31:0] push_data, pull_data;
  logic [7:0]  sp_load_val, mem_data_in, mem_data_out, sp;
  logic [15:0] mem_addr;
  logic        mem_write_en, mem_read_en, busy, done, wrap;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        we;
    logic        re;
    logic        busy;
    logic        done;
    logic [15:0] addr;
    logic [7:0]  dout;
  } obs_t;

  obs_t obs;
  assign obs = {mem_write_en, mem_read_en, busy, done, mem_addr, mem_data_out};

  ie_stack_seq dut (
    .clk          (clk),
    .rst          (rst),
    .halt         (halt),
    .start        (start),
    .op_pull      (op_pull),
    .nbytes       (nbytes),
    .push_data    (push_data),
    .sp_load      (sp_load),
    .sp_load_val  (sp_load_val),
    .mem_data_in  (mem_data_in),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .sp           (sp),
    .pull_data    (pull_data),
    .busy         (busy),
    .done         (done),
    .wrap         (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stack page memory: address registered by the DUT, one more register here
  logic [7:0] mem [0:255];
  logic [7:0] rd_q;
  assign mem_data_in = rd_q;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      rd_q <= 8'h00;
    end else if (!halt) begin
      if (mem_write_en) mem[mem_addr[7:0]] <= mem_data_out;
      rd_q <= mem[mem_addr[7:0]];
    end
  end

  function automatic obs_t mk(input logic [3:0] f, input logic [15:0] a, input logic [7:0] d);
    return {f, a, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic pull, input logic [2:0] n, input logic [31:0] d);
    start     = 1'b1;
    op_pull   = pull;
    nbytes    = n;
    push_data = d;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_tests++;
    if (obs !== mk(4'b0000, 16'h0000, 8'h00) || pull_data !== 32'h0 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got %h/%h/%b exp 0", obs, pull_data, wrap);
    end
    n_tests++;
    if (sp !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_sp got %h exp ff", sp);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (obs !== mk(4'b0000, 16'h0000, 8'h00) || sp !== 8'hFF) begin
      n_fail++;
      $display("FAIL reset_release got %h sp %h", obs, sp);
    end
  endtask

  task automatic test_push();
    obs_t exp [5];
    exp[0] = mk(4'b0010, 16'h0000, 8'h00);
    exp[1] = mk(4'b1010, 16'h01FF, 8'h12);
    exp[2] = mk(4'b1010, 16'h01FE, 8'h34);
    exp[3] = mk(4'b0001, 16'h01FE, 8'h34);
    exp[4] = mk(4'b0000, 16'h01FE, 8'h34);
    go(1'b0, 3'd2, 32'h0000_3412);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      n_tests++;
      if (obs !== exp[c]) begin
        n_fail++;
        $display("FAIL push_c%0d got %h exp %h", c, obs, exp[c]);
      end
    end
    n_tests++;
    if (sp !== 8'hFD || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL push_sp_wrap got %h/%b exp fd/0", sp, wrap);
    end
  endtask

  task automatic test_pull();
    obs_t exp [5];
    exp[0] = mk(4'b0010, 16'h01FE, 8'h34);
    exp[1] = mk(4'b0110, 16'h01FE, 8'h34);
    exp[2] = mk(4'b0110, 16'h01FF, 8'h34);
    exp[3] = mk(4'b0010, 16'h01FF, 8'h34);
    exp[4] = mk(4'b0001, 16'h01FF, 8'h34);
    go(1'b1, 3'd2, 32'h0);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) tick();
      n_tests++;
      if (obs !== exp[c]) begin
        n_fail++;
        $display("FAIL pull_c%0d got %h exp %h", c, obs, exp[c]);
      end
    end
    n_tests++;
    if (pull_data !== 32'h0000_1234 || sp !== 8'hFF) begin
      n_fail++;
      $display("FAIL pull_data_sp got %h/%h exp 00001234/ff", pull_data, sp);
    end
  endtask

  task automatic test_wrap();
    obs_t ep [3];
    obs_t el [4];
    sp_load     = 1'b1;
    sp_load_val = 8'h00;
    tick();
    sp_load = 1'b0;
    n_tests++;
    if (sp !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_sp_load got %h exp 00", sp);
    end
    ep[0] = mk(4'b0010, 16'h01FF, 8'h34);
    ep[1] = mk(4'b1010, 16'h0100, 8'hAA);
    ep[2] = mk(4'b0001, 16'h0100, 8'hAA);
    go(1'b0, 3'd1, 32'h0000_00AA);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      n_tests++;
      if (obs !== ep[c]) begin
        n_fail++;
        $display("FAIL wrap_push_c%0d got %h exp %h", c, obs, ep[c]);
      end
    end
    n_tests++;
    if (sp !== 8'hFF || wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_push_flag got %h/%b exp ff/1", sp, wrap);
    end
    el[0] = mk(4'b0010, 16'h0100, 8'hAA);
    el[1] = mk(4'b0110, 16'h0100, 8'hAA);
    el[2] = mk(4'b0010, 16'h0100, 8'hAA);
    el[3] = mk(4'b0001, 16'h0100, 8'hAA);
    go(1'b1, 3'd1, 32'h0);
    n_tests++;
    if (wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_clear_on_start got %b exp 0", wrap);
    end
    for (int c = 0; c < 4; c++) begin
      if (c > 0) tick();
      n_tests++;
      if (obs !== el[c]) begin
        n_fail++;
        $display("FAIL wrap_pull_c%0d got %h exp %h", c, obs, el[c]);
      end
    end
    n_tests++;
    if (sp !== 8'h00 || wrap !== 1'b1 || pull_data !== 32'h0000_12AA) begin
      n_fail++;
      $display("FAIL wrap_pull_state got %h/%b/%h exp 00/1/000012aa", sp, wrap, pull_data);
    end
    go(1'b0, 3'd0, 32'h0);
    n_tests++;
    if (obs !== mk(4'b0010, 16'h0100, 8'hAA) || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_c0 got %h/%b exp busy, wrap 0", obs, wrap);
    end
    tick();
    n_tests++;
    if (obs !== mk(4'b0001, 16'h0100, 8'hAA) || sp !== 8'h00) begin
      n_fail++;
      $display("FAIL zero_c1 got %h sp %h exp done only", obs, sp);
    end
  endtask

  task automatic test_clamp_ignore();
    obs_t exp [8];
    int   writes = 0;
    sp_load     = 1'b1;
    sp_load_val = 8'hFF;
    tick();
    sp_load = 1'b0;
    exp[0] = mk(4'b0010, 16'h0100, 8'hAA);
    exp[1] = mk(4'b1010, 16'h01FF, 8'h11);
    exp[2] = mk(4'b1010, 16'h01FE, 8'h22);
    exp[3] = mk(4'b1010, 16'h01FD, 8'h33);
    exp[4] = mk(4'b1010, 16'h01FC, 8'h44);
    exp[5] = mk(4'b0001, 16'h01FC, 8'h44);
    exp[6] = mk(4'b0000, 16'h01FC, 8'h44);
    exp[7] = mk(4'b0000, 16'h01FC, 8'h44);
    go(1'b0, 3'd7, 32'h4433_2211);
    for (int c = 0; c < 8; c++) begin
      if (c == 2) begin
        start   = 1'b1;
        op_pull = 1'b1;
        nbytes  = 3'd1;
      end
      if (c == 3) begin
        start       = 1'b0;
        sp_load     = 1'b1;
        sp_load_val = 8'h55;
      end
      if (c == 4) sp_load = 1'b0;
      if (c > 0) tick();
      if (mem_write_en) writes++;
      n_tests++;
      if (obs !== exp[c]) begin
        n_fail++;
        $display("FAIL clamp_c%0d got %h exp %h", c, obs, exp[c]);
      end
    end
    n_tests++;
    if (writes != 4 || sp !== 8'hFB) begin
      n_fail++;
      $display("FAIL clamp_count got %0d writes sp %h exp 4 fb", writes, sp);
    end
  endtask

  task automatic test_halt();
    obs_t exp [9];
    exp[0] = mk(4'b0010, 16'h01FC, 8'h44);
    exp[1] = mk(4'b0110, 16'h01FC, 8'h44);
    exp[2] = mk(4'b0110, 16'h01FD, 8'h44);
    exp[3] = mk(4'b0110, 16'h01FD, 8'h44);
    exp[4] = mk(4'b0110, 16'h01FD, 8'h44);
    exp[5] = mk(4'b0110, 16'h01FD, 8'h44);
    exp[6] = mk(4'b0110, 16'h01FE, 8'h44);
    exp[7] = mk(4'b0010, 16'h01FE, 8'h44);
    exp[8] = mk(4'b0001, 16'h01FE, 8'h44);
    go(1'b1, 3'd3, 32'h0);
    for (int c = 0; c < 9; c++) begin
      if (c == 3) halt = 1'b1;
      if (c == 6) halt = 1'b0;
      if (c > 0) tick();
      n_tests++;
      if (obs !== exp[c]) begin
        n_fail++;
        $display("FAIL halt_c%0d got %h exp %h", c, obs, exp[c]);
      end
    end
    n_tests++;
    if (pull_data !== 32'h0022_3344 || sp !== 8'hFE) begin
      n_fail++;
      $display("FAIL halt_result got %h/%h exp 00223344/fe", pull_data, sp);
    end
  endtask

  task automatic test_reset_mid_burst();
    obs_t exp [3];
    go(1'b0, 3'd3, 32'h00CC_BBAA);
    tick();
    n_tests++;
    if (obs !== mk(4'b1010, 16'h01FE, 8'hAA)) begin
      n_fail++;
      $display("FAIL rstmid_first got %h exp %h", obs, mk(4'b1010, 16'h01FE, 8'hAA));
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (obs !== mk(4'b0000, 16'h0000, 8'h00) || sp !== 8'hFF || pull_data !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_async got %h sp %h pd %h exp 0/ff/0", obs, sp, pull_data);
    end
    #2;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_tests++;
      if (obs !== mk(4'b0000, 16'h0000, 8'h00)) begin
        n_fail++;
        $display("FAIL rstmid_quiet_c%0d got %h exp 0", c, obs);
      end
    end
    exp[0] = mk(4'b0010, 16'h0000, 8'h00);
    exp[1] = mk(4'b1010, 16'h01FF, 8'h5A);
    exp[2] = mk(4'b0001, 16'h01FF, 8'h5A);
    go(1'b0, 3'd1, 32'h0000_005A);
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      n_tests++;
      if (obs !== exp[c]) begin
        n_fail++;
        $display("FAIL rstmid_next_c%0d got %h exp %h", c, obs, exp[c]);
      end
    end
    n_tests++;
    if (sp !== 8'hFE) begin
      n_fail++;
      $display("FAIL rstmid_next_sp got %h exp fe", sp);
    end
  endtask

  initial begin
    rst         = 1'b1;
    halt        = 1'b0;
    start       = 1'b0;
    op_pull     = 1'b0;
    nbytes      = 3'd0;
    push_data   = 32'h0;
    sp_load     = 1'b0;
    sp_load_val = 8'h00;
    test_reset();
    test_push();
    test_pull();
    test_wrap();
    test_clamp_ignore();
    test_halt();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ie_stack_seq.md
Name: ie_stack_seq

Overview:
- Parametrised stack-transfer sequencer for the CPU execute unit.
- Performs multi-byte push or pull bursts on the page-relative hardware stack, e.g. JSR/RTS return addresses or interrupt PC+status frames.
- Owns the stack pointer and drives a private memory-bus port. The execute FSM muxes this port onto the CPU bus the same way it muxes the interrupt handler.
- Generalises single-byte push/pull with configurable burst length, read latency, stack page and wrap detection.

Parameters:
- DATA_W, 8, memory data width.
- ADDR_W, 16, memory address width.
- SP_W, 8, stack pointer width. ADDR_W >= SP_W + 1.
- STACK_PAGE, 8'h01, upper address bits; mem_addr = {STACK_PAGE, sp}.
- MAX_BYTES, 4, largest burst.
- RD_LAT, 2, number of clock edges from read request to data sample. Must be >= 1.
- SP_RESET, 8'hFF, stack pointer value after reset.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- halt  in  1  freeze; all registers hold while 1
- start  in  1  begin burst (sampled only in IDLE)
- op_pull  in  1  0 = push, 1 = pull
- nbytes  in  $clog2(MAX_BYTES+1)  burst length; values > MAX_BYTES are clamped
- push_data  in  MAX_BYTES*DATA_W  byte k in bits [k*DATA_W +: DATA_W]; byte 0 is pushed first
- sp_load  in  1  load sp from sp_load_val (IDLE only)
- sp_load_val  in  SP_W  new stack pointer
- mem_data_in  in  DATA_W  read data
- mem_addr  out  ADDR_W  registered address
- mem_data_out  out  DATA_W  registered write data
- mem_write_en  out  1  one-cycle write strobe per byte
- mem_read_en  out  1  one-cycle read strobe per byte
- sp  out  SP_W  current stack pointer
- pull_data  out  MAX_BYTES*DATA_W  byte k = k-th byte pulled; unpulled lanes hold their old value
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse at burst completion
- wrap  out  1  sticky; set if sp wrapped during the burst; cleared on the next accepted start

Behaviour:
- Reset values:
  - sp = SP_RESET.
  - mem_addr, mem_data_out, pull_data = 0.
  - mem_write_en, mem_read_en, busy, done, wrap = 0.
  - State = IDLE.
  - Reset mid-burst aborts immediately: no done pulse, no further strobes.
- States: IDLE, PUSH, PULL, DRAIN, FINISH.
- IDLE:
  - start=1 latches op_pull, n = min(nbytes, MAX_BYTES) and push_data; clears wrap; sets busy.
  - n=0 → FINISH (no bus activity).
  - Otherwise go to PUSH or PULL.
  - sp_load=1 with start=0 loads sp.
  - If both are 1, start wins and sp_load is ignored. sp_load outside IDLE is ignored.
- PUSH, one byte per cycle, at the edge:
  - mem_addr = {STACK_PAGE, sp}, mem_data_out = byte k, mem_write_en = 1, sp = sp-1.
  - After n bytes → FINISH; mem_write_en deasserts on the next edge.
  - Push of n bytes: done asserts in cycle n+1 after the start edge.
- PULL, one request per cycle (pipelined), at the edge:
  - mem_addr = {STACK_PAGE, sp+1}, mem_read_en = 1, sp = sp+1.
  - A lane-index/valid shift register of depth RD_LAT tags each request.
  - The request issued at edge E has mem_data_in sampled at edge E+RD_LAT into lane k.
  - After the last issue → DRAIN until all tags retire, then FINISH.
  - Pull of n bytes: done in cycle n+RD_LAT after the start edge.
- FINISH: done=1 for one cycle, busy=0 on the same edge, return to IDLE. start is accepted again the cycle after done.
- Arithmetic: sp is modulo 2^SP_W. Push from sp=0 gives addr {PAGE,0} and sp=max. Pull from sp=max reads {PAGE,0}. Either case sets wrap=1 and the burst continues normally.
- halt=1 freezes state, sp, counters, the tag pipeline and all outputs, including strobes held high. The memory system is halted concurrently, so mem_data_in is stable and the pipeline resumes unchanged.
- start while busy is ignored, with no queueing.

Decomposition:
- Shared package ie_defs holds:
  - a stack_op enum {STK_PUSH, STK_PULL};
  - a localparam STACK_PAGE_DEFAULT = 8'h01;
  - a localparam SP_RESET_DEFAULT = 8'hFF.
- One natural sub-module: ie_rd_tag_pipe (RD_LAT-deep valid+lane-index shift register with halt-enable). The rest is inline.

Test Plan:
- Push, sp=FF, n=2, bytes {0x12,0x34} → writes 01FF←12 then 01FE←34 on consecutive cycles; sp=FD; done in cycle 3; wrap=0.
- Pull, sp=FD, n=2, memory 01FE=34, 01FF=12, RD_LAT=2 → read strobes at 01FE and 01FF back-to-back; pull_data lane0=34, lane1=12; sp=FF; done in cycle 4.
- Wrap: sp_load 00, push n=1 data 0xAA → write 0100←AA; sp=FF; wrap=1. A following pull n=1 → reads 0100; sp=00; wrap=1 again. A start with n=0 clears wrap and pulses done in cycle 1 with no strobes.
- Clamp and ignore rules: nbytes=7 with MAX_BYTES=4 → exactly 4 writes. start asserted while busy → no effect. sp_load while busy → sp unchanged.
- halt for 3 cycles in the middle of a 3-byte pull → strobes and addresses held during halt; after release, lanes are correct, no duplicated or missing reads, and done is delayed by exactly 3 cycles.
- rst pulsed after the first of 3 pushes → strobes drop asynchronously; sp=FF; busy=0; no done; the next push starts cleanly.
